eth_tx_pkt_rr_arb: RTL
======================

Name: eth_tx_pkt_rr_arb

Overview:
Packet-granular round-robin arbiter that shares one HSSI SS TX AXI-S channel among NUM_SRC requesters (e.g. HE-HSSI traffic generator, loopback, host DMA). A grant is held from the first beat to the tlast beat, so packets never interleave. The block honours MAC pause XOFF at packet boundaries only and drives a registered master stream into the HSSI SS TX port.

Parameters:
NUM_SRC, 4, number of requesting AXI-S sources (2..8)
DATA_W, 64, tdata width per source and on the master (64 for 10G/25G, 512 for 100G)
CLIENT_W, 2, width of the tuser client field passed through
SRC_ID_W, $clog2(NUM_SRC), width of the granted-source index (derived, minimum 1)

Ports:
clk  in  1  TX AXI-S clock
rst_n  in  1  asynchronous active-low reset
s_tvalid  in  NUM_SRC  per-source valid
s_tready  out  NUM_SRC  per-source ready
s_tdata  in  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
s_tkeep  in  NUM_SRC*DATA_W/8  per-source byte enables
s_tlast  in  NUM_SRC  per-source end of packet
s_tuser_client  in  NUM_SRC*CLIENT_W  per-source client bits
m_tvalid  out  1  master valid
m_tready  in  1  master ready from HSSI SS
m_tdata  out  DATA_W  master data
m_tkeep  out  DATA_W/8  master byte enables
m_tlast  out  1  master end of packet
m_tuser_client  out  CLIENT_W  master client bits
pause_xoff  in  1  level; when high, no new packet is granted
grant_id  out  SRC_ID_W  source currently or last granted
pkt_done  out  1  one-cycle pulse when a tlast beat is accepted from a source

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant_id=0, m_tvalid=0, m_tlast=0, m_tdata/m_tkeep/m_tuser_client=0, s_tready=0, pkt_done=0.
- Output stage is a single register. load_en = !m_tvalid || m_tready. The master payload holds stable while m_tvalid && !m_tready.
- State IDLE: if !pause_xoff and any s_tvalid, pick the first requesting index starting at rr_ptr, wrapping modulo NUM_SRC. Register the winner into grant_id and go to LOCKED. No data transfers in this cycle (1-cycle arbitration bubble). If no request, or pause_xoff is high, stay in IDLE.
- State LOCKED: s_tready[grant_id] = load_en; all other s_tready = 0. On s_tvalid[grant_id] && s_tready[grant_id], load the beat into the output register with m_tvalid=1. If load_en and the granted source has no valid beat, m_tvalid=0 next cycle.
- On an accepted beat with s_tlast=1: pkt_done pulses next cycle, rr_ptr = (grant_id+1) mod NUM_SRC (wrap at NUM_SRC-1 goes to 0), return to IDLE.
- pause_xoff asserted mid-packet has no effect until the packet's tlast is accepted. It is sampled only in IDLE.
- Latency: the first beat appears on m_* two cycles after s_tvalid in IDLE (arbitration cycle plus register). Throughput is 1 beat/cycle within a packet. There is one idle cycle between packets.
- A source that deasserts s_tvalid mid-packet keeps the grant; the arbiter waits indefinitely. There is no timeout.
- Single-beat packets (tlast on first beat) are legal; the grant is released after that one beat.
- s_tready is combinational from m_tready and state. There is no combinational path from s_tvalid to s_tready.
- s_tkeep is passed through unchanged. There is no zero-keep checking.

Test Plan:
- Single source: src1 sends a 3-beat packet, m_tready=1 -> m_* beats identical, m_tlast on beat 3, grant_id=1, pkt_done one pulse, first beat 2 cycles after s_tvalid.
- Fairness: all 4 sources continuously send 2-beat packets from reset -> grant order 0,1,2,3,0,1…, no interleaving, each tlast followed by exactly one idle cycle.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, m_tdata stable while stalled, s_tready[grant]=0 in stall cycles.
- Pause: pause_xoff rises at beat 2 of a 5-beat packet -> all 5 beats delivered; with src2 pending, no new grant until pause_xoff falls, then src2 granted the next cycle.
- Wrap/skip: rr_ptr=3, only src1 requesting -> src1 granted; after its tlast, rr_ptr=2.
- Reset mid-packet: assert rst_n=0 at beat 2 -> m_tvalid=0 and s_tready=0 immediately. After release, state=IDLE and rr_ptr=0; a new packet from src0 transfers normally.

Source files
------------

// File: rtl/eth_tx_pkt_rr_arb.sv
// Packet-granular round-robin arbiter that merges NUM_SRC AXI-S sources onto one
// registered TX stream. The grant is held from first beat to tlast, and XOFF is honoured only between packets.
module eth_tx_pkt_rr_arb #(
  parameter int NUM_SRC  = 4,
  parameter int DATA_W   = 64,
  parameter int CLIENT_W = 2,
  parameter int SRC_ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             s_tvalid,
  output logic [NUM_SRC-1:0]             s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]      s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0]    s_tkeep,
  input  logic [NUM_SRC-1:0]             s_tlast,
  input  logic [NUM_SRC*CLIENT_W-1:0]    s_tuser_client,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_W-1:0]              m_tdata,
  output logic [DATA_W/8-1:0]            m_tkeep,
  output logic                           m_tlast,
  output logic [CLIENT_W-1:0]            m_tuser_client,
  input  logic                           pause_xoff,
  output logic [SRC_ID_W-1:0]            grant_id,
  output logic                           pkt_done
);

  localparam int                  KEEP_W     = DATA_W / 8;
  localparam logic [SRC_ID_W:0]   LP_NUM_SRC = (SRC_ID_W + 1)'(NUM_SRC);
  localparam logic [SRC_ID_W-1:0] LP_LAST_ID = SRC_ID_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_ID_W-1:0]   r_rr_ptr;
  logic [SRC_ID_W-1:0]   r_grant_id;
  logic                  r_m_tvalid;
  logic [DATA_W-1:0]     r_m_tdata;
  logic [KEEP_W-1:0]     r_m_tkeep;
  logic                  r_m_tlast;
  logic [CLIENT_W-1:0]   r_m_tuser;
  logic                  r_pkt_done;

  logic                  w_load_en;
  logic [NUM_SRC-1:0]    w_gsel;
  logic [NUM_SRC-1:0]    w_s_tready;
  logic                  w_accept;
  logic                  w_accept_last;
  logic [DATA_W-1:0]     w_sel_data;
  logic [KEEP_W-1:0]     w_sel_keep;
  logic                  w_sel_last;
  logic [CLIENT_W-1:0]   w_sel_user;
  logic [SRC_ID_W:0]     w_scan_raw;
  logic [SRC_ID_W:0]     w_scan_sum;
  logic                  w_scan_hit;
  logic                  w_win_found;
  logic [SRC_ID_W-1:0]   w_win_id;

  assign w_load_en = !r_m_tvalid || m_tready;

  // One-hot decode of the held grant
  always_comb begin
    w_gsel             = '0;
    w_gsel[r_grant_id] = 1'b1;
  end

  // Payload mux for the granted source (AND-OR so it stays a flat mux)
  always_comb begin
    w_sel_data = '0;
    w_sel_keep = '0;
    w_sel_last = 1'b0;
    w_sel_user = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel_data = w_sel_data | (s_tdata[i*DATA_W +: DATA_W] & {DATA_W{w_gsel[i]}});
      w_sel_keep = w_sel_keep | (s_tkeep[i*KEEP_W +: KEEP_W] & {KEEP_W{w_gsel[i]}});
      w_sel_last = w_sel_last | (s_tlast[i] & w_gsel[i]);
      w_sel_user = w_sel_user | (s_tuser_client[i*CLIENT_W +: CLIENT_W] & {CLIENT_W{w_gsel[i]}});
    end
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_scan_raw  = '0;
    w_scan_sum  = '0;
    w_scan_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_scan_raw  = {1'b0, r_rr_ptr} + (SRC_ID_W + 1)'(i);
      w_scan_sum  = (w_scan_raw >= LP_NUM_SRC) ? (w_scan_raw - LP_NUM_SRC) : w_scan_raw;
      w_scan_hit  = !w_win_found && s_tvalid[w_scan_sum[SRC_ID_W-1:0]];
      w_win_id    = w_scan_hit ? w_scan_sum[SRC_ID_W-1:0] : w_win_id;
      w_win_found = w_win_found | w_scan_hit;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; XOFF is only looked at while idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!pause_xoff && w_win_found) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_accept_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready goes only to the granted source, gated by output-stage space
  always_comb begin
    w_s_tready = '0;
    case (r_state)
      ST_LOCKED: w_s_tready = w_gsel & {NUM_SRC{w_load_en}};
      ST_IDLE:   w_s_tready = '0;
      default:   w_s_tready = '0;
    endcase
  end

  assign w_accept      = |(s_tvalid & w_s_tready);
  assign w_accept_last = w_accept && w_sel_last;

  // Grant index and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED) begin
        r_grant_id <= w_win_id;
      end
      if (w_accept_last) begin
        r_rr_ptr <= (r_grant_id == LP_LAST_ID) ? '0 : (r_grant_id + SRC_ID_W'(1));
      end
    end
  end

  // Single-register output stage; payload is frozen while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= w_accept_last;
      if (w_load_en) begin
        r_m_tvalid <= w_accept;
        if (w_accept) begin
          r_m_tdata <= w_sel_data;
          r_m_tkeep <= w_sel_keep;
          r_m_tlast <= w_sel_last;
          r_m_tuser <= w_sel_user;
        end
      end
    end
  end

  assign s_tready       = w_s_tready;
  assign m_tvalid       = r_m_tvalid;
  assign m_tdata        = r_m_tdata;
  assign m_tkeep        = r_m_tkeep;
  assign m_tlast        = r_m_tlast;
  assign m_tuser_client = r_m_tuser;
  assign grant_id       = r_grant_id;
  assign pkt_done       = r_pkt_done;

endmodule
